score_card_keeper: RTL

- Sits directly downstream of the score calculator. Takes the calculated category score and commits it into the active player's scorecard.
- Tracks which of the 12 categories each player has used, keeps the per-player upper-section subtotal and applies the upper bonus.
- Drives both players' running totals and the game-over flag to the game FSM and the LCD path.
- Fixed-latency, multi-cycle commit handshake, with duplicate and illegal-category rejection.

---
 rtl/score_card_if.sv | 34 +++
 rtl/score_card_keeper.sv | 116 +++++++++++
 2 files changed

// File: rtl/score_card_if.sv
// Handshake and scorecard bus between the game FSM and score_card_keeper.
// The master modport is the upstream side; the slave modport is the keeper.
interface score_card_if #(
    parameter int NUM_CAT = 12,
    parameter int SCORE_W = 9
);
    logic               new_game;
    logic               commit;
    logic               player;
    logic [3:0]         category_idx;
    logic [7:0]         score_in;
    logic               busy;
    logic               commit_ack;
    logic               commit_err;
    logic [SCORE_W-1:0] p1_total;
    logic [SCORE_W-1:0] p2_total;
    logic [NUM_CAT-1:0] p1_used;
    logic [NUM_CAT-1:0] p2_used;
    logic               p1_bonus;
    logic               p2_bonus;
    logic               game_over;

    modport master (
        output new_game, commit, player, category_idx, score_in,
        input  busy, commit_ack, commit_err, p1_total, p2_total,
               p1_used, p2_used, p1_bonus, p2_bonus, game_over
    );

    modport slave (
        input  new_game, commit, player, category_idx, score_in,
        output busy, commit_ack, commit_err, p1_total, p2_total,
               p1_used, p2_used, p1_bonus, p2_bonus, game_over
    );
endinterface

// File: rtl/score_card_keeper.sv
// Commits calculated category scores into the two players' scorecards.
// Define UPPER_BONUS_EN to enable the upper-section bonus; otherwise no bonus is ever awarded.
module score_card_keeper #(
    parameter int NUM_CAT      = 12,
    parameter int BONUS_THRESH = 63,
    parameter int BONUS_PTS    = 35,
    parameter int SCORE_W      = 9
) (
    input  logic        clk,
    input  logic        reset_n,
    score_card_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CHECK, WRITE, BONUS, ERR} state_t;

    typedef struct packed {
        logic       player;
        logic [3:0] idx;
        logic [7:0] score;
    } req_t;

    localparam logic [3:0] CAT_LIM   = 4'(NUM_CAT);
    localparam logic [3:0] UPPER_LIM = 4'd6;

    state_t                   state;
    req_t                     req;
    logic [1:0][NUM_CAT-1:0]  used;
    logic [1:0][SCORE_W-1:0]  total;
    logic                     game_over;
    logic                     ack;
    logic                     err;
    logic [15:0]              used_ext;
    logic                     reject;
`ifdef UPPER_BONUS_EN
    logic [1:0][6:0]          upper;
    logic [1:0]               bonus;
`endif

    // Widen the mask so an out-of-range index never selects outside the vector.
    always_comb begin
        used_ext = 16'(used[req.player]);
        reject   = (req.idx >= CAT_LIM) || used_ext[req.idx] || game_over;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || bus.new_game) begin
            state     <= IDLE;
            req       <= '0;
            used      <= '0;
            total     <= '0;
            game_over <= 1'b0;
            ack       <= 1'b0;
            err       <= 1'b0;
`ifdef UPPER_BONUS_EN
            upper     <= '0;
            bonus     <= '0;
`endif
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.commit) begin
                        req   <= '{player: bus.player, idx: bus.category_idx, score: bus.score_in};
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (reject) begin
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        state <= WRITE;
                    end
                end
                ERR: state <= IDLE;
                WRITE: begin
                    total[req.player]          <= total[req.player] + SCORE_W'(req.score);
                    used[req.player][req.idx]  <= 1'b1;
`ifdef UPPER_BONUS_EN
                    if (req.idx < UPPER_LIM)
                        upper[req.player] <= upper[req.player] + req.score[6:0];
`endif
                    state <= BONUS;
                end
                BONUS: begin
`ifdef UPPER_BONUS_EN
                    if (upper[req.player] >= 7'(BONUS_THRESH) && !bonus[req.player]) begin
                        total[req.player] <= total[req.player] + SCORE_W'(BONUS_PTS);
                        bonus[req.player] <= 1'b1;
                    end
`endif
                    ack       <= 1'b1;
                    game_over <= &used;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.commit_ack = ack;
    assign bus.commit_err = err;
    assign bus.p1_total   = total[0];
    assign bus.p2_total   = total[1];
    assign bus.p1_used    = used[0];
    assign bus.p2_used    = used[1];
    assign bus.game_over  = game_over;
`ifdef UPPER_BONUS_EN
    assign bus.p1_bonus   = bonus[0];
    assign bus.p2_bonus   = bonus[1];
`else
    assign bus.p1_bonus   = 1'b0;
    assign bus.p2_bonus   = 1'b0;
`endif
endmodule
